keypad_scan: RTL and testbench

4x4 matrix keypad scanner for the clock's time-set front panel: the input-side counterpart of the seven-segment scan driver. It drives one row low at a time and samples the four column lines through a synchronizer. Full-matrix snapshots are debounced, and each clean single-key press is reported as a 4-bit key code with a one-cycle valid pulse. The time-set controller consumes these events to step HH/MM/SS and select the blink field.

---
 rtl/keypad_scan.sv | 174 +++++++++++++++++
 tb/tb_keypad_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row-strobed column sampling, whole-frame debounce,
// and single-key press/release event generation for the time-set front panel.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_down
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ST_IDLE, ST_DOWN, ST_BLOCK} state_t;

  function automatic logic [4:0] popcount(input logic [15:0] f);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, f[i]};
    return n;
  endfunction

  function automatic logic [3:0] first_set(input logic [15:0] f);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (f[i]) idx = 4'(i);
    return idx;
  endfunction

  logic [3:0]        col_meta_q, col_s_q;
  logic [SLOT_W-1:0] slot_cnt_q;
  logic [1:0]        row_q;
  logic [15:0]       frame_q;
  logic              frame_done_q;
  logic [15:0]       prev_frame_q, prev_frame_d;
  logic [STAB_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [15:0]       deb_frame_q, deb_frame_d;
  logic              deb_upd_q, deb_upd_d;
  state_t            state_q, state_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_release_q, key_release_d;
  logic              key_down_q, key_down_d;
  logic              slot_last;

  assign slot_last = (slot_cnt_q == SLOT_LAST);

  // Synchronizer idles at all-ones so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      row_q        <= 2'd0;
      frame_q      <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= slot_last && (row_q == 2'd3);
      if (slot_last) begin
        slot_cnt_q                  <= '0;
        row_q                       <= row_q + 2'd1;
        frame_q[{row_q, 2'b00} +: 4] <= ~col_s_q;
      end else begin
        slot_cnt_q <= slot_cnt_q + 1'b1;
      end
    end
  end

  assign row_out = ~(4'b0001 << row_q);

  // Acceptance looks at the post-update count so a frame can commit on the same frame_done
  always_comb begin
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    deb_frame_d  = deb_frame_q;
    deb_upd_d    = 1'b0;
    if (frame_done_q) begin
      if (frame_q == prev_frame_q) begin
        if (stable_cnt_q < STAB_MAX) stable_cnt_d = stable_cnt_q + 1'b1;
      end else begin
        prev_frame_d = frame_q;
        stable_cnt_d = STAB_W'(1);
      end
      if ((stable_cnt_d == STAB_MAX) && (prev_frame_d != deb_frame_q)) begin
        deb_frame_d = prev_frame_d;
        deb_upd_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame_q <= 16'd0;
      stable_cnt_q <= '0;
      deb_frame_q  <= 16'd0;
      deb_upd_q    <= 1'b0;
    end else begin
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      deb_frame_q  <= deb_frame_d;
      deb_upd_q    <= deb_upd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_down_d    = key_down_q;
    if (deb_upd_q) begin
      case (state_q)
        ST_IDLE: begin
          if (popcount(deb_frame_q) == 5'd1) begin
            state_d     = ST_DOWN;
            key_code_d  = first_set(deb_frame_q);
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
          end else if (popcount(deb_frame_q) >= 5'd2) begin
            state_d = ST_BLOCK;
          end
        end
        ST_DOWN: begin
          // deb_upd only fires on a change, so the held key is no longer sole
          key_release_d = 1'b1;
          key_down_d    = 1'b0;
          state_d       = (deb_frame_q == 16'd0) ? ST_IDLE : ST_BLOCK;
        end
        ST_BLOCK: begin
          if (deb_frame_q == 16'd0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_down_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_down_q    <= key_down_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign key_down    = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a behavioural 4x4 matrix drives col_in from
// row_out and a set of held keys; event timing is measured in clock cycles.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;
  logic        key_down;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int n_valid = 0, n_release = 0, n_both = 0;
  int t_valid = 0, t_release = 0;
  int v0, r0, p;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Closed switch pulls its column low while its row is driven
  always_comb begin
    case (row_out)
      4'b1110: col_in = ~keys[3:0];
      4'b1101: col_in = ~keys[7:4];
      4'b1011: col_in = ~keys[11:8];
      4'b0111: col_in = ~keys[15:12];
      default: col_in = 4'hF;
    endcase
  end

  always @(negedge clk) begin
    if (key_valid) begin
      n_valid <= n_valid + 1;
      t_valid <= cyc;
    end
    if (key_release) begin
      n_release <= n_release + 1;
      t_release <= cyc;
    end
    if (key_valid && key_release) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int k);
    while (cyc - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", {28'd0, row_out}, 32'hE);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_release", {31'd0, key_release}, 32'd0);
    chk("rst_down", {31'd0, key_down}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    chk("scan_r0", {28'd0, row_out}, 32'hE);
    run_to(4);
    chk("scan_r1", {28'd0, row_out}, 32'hD);
    run_to(8);
    chk("scan_r2", {28'd0, row_out}, 32'hB);
    run_to(12);
    chk("scan_r3", {28'd0, row_out}, 32'h7);
    run_to(16);
    chk("scan_wrap", {28'd0, row_out}, 32'hE);
    run_to(64);
    chk("idle_no_valid", n_valid, 0);
    chk("idle_no_release", n_release, 0);

    // single press of key 6 from a frame boundary
    v0 = n_valid; r0 = n_release;
    keys = 16'h0040; p = cyc;
    run_to(144);
    chk("press6_count", n_valid - v0, 1);
    chk("press6_latency", t_valid - p, 50);
    chk("press6_code", {28'd0, key_code}, 32'd6);
    chk("press6_down", {31'd0, key_down}, 32'd1);
    chk("press6_no_release", n_release - r0, 0);

    v0 = n_valid; r0 = n_release;
    keys = 16'h0000; p = cyc;
    run_to(208);
    chk("rel6_count", n_release - r0, 1);
    chk("rel6_latency", t_release - p, 50);
    chk("rel6_down", {31'd0, key_down}, 32'd0);
    chk("rel6_code_held", {28'd0, key_code}, 32'd6);
    chk("rel6_no_valid", n_valid - v0, 0);

    // key 9 bouncing on alternate frames, then held
    v0 = n_valid; r0 = n_release;
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      run_to(208 + 16 * (f + 1));
    end
    chk("bounce_no_valid", n_valid - v0, 0);
    chk("bounce_no_release", n_release - r0, 0);
    keys = 16'h0200; p = cyc;
    run_to(368);
    chk("press9_count", n_valid - v0, 1);
    chk("press9_latency", t_valid - p, 50);
    chk("press9_code", {28'd0, key_code}, 32'd9);
    chk("press9_down", {31'd0, key_down}, 32'd1);
    keys = 16'h0000; r0 = n_release;
    run_to(432);
    chk("rel9_count", n_release - r0, 1);

    // two keys together lock out reporting until full release
    v0 = n_valid;
    keys = 16'h8001;
    run_to(496);
    chk("multi_no_valid", n_valid - v0, 0);
    keys = 16'h0001;
    run_to(560);
    chk("block_no_valid", n_valid - v0, 0);
    chk("block_down", {31'd0, key_down}, 32'd0);
    chk("block_code_held", {28'd0, key_code}, 32'd9);
    keys = 16'h0000;
    run_to(624);
    keys = 16'h0008; p = cyc;
    run_to(688);
    chk("press3_count", n_valid - v0, 1);
    chk("press3_code", {28'd0, key_code}, 32'd3);
    chk("press3_latency", t_valid - p, 50);
    keys = 16'h0000;
    run_to(752);

    // reset lands in row 2 of the third debounce frame of a key-5 press
    keys = 16'h0020; v0 = n_valid;
    run_to(793);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row", {28'd0, row_out}, 32'hE);
    chk("mid_rst_code", {28'd0, key_code}, 32'd0);
    chk("mid_rst_down", {31'd0, key_down}, 32'd0);
    chk("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    chk("mid_rst_release", {31'd0, key_release}, 32'd0);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_valid", n_valid - v0, 0);
    rst_n = 1'b1;
    base  = cyc;
    run_to(64);
    chk("press5_count", n_valid - v0, 1);
    chk("press5_latency", t_valid - base, 50);
    chk("press5_code", {28'd0, key_code}, 32'd5);
    chk("press5_down", {31'd0, key_down}, 32'd1);

    chk("pulse_exclusive", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
